gpi_debounce: RTL and testbench
===============================

// Module: gpi_debounce
// PURPOSE
//   Conditions the raw board switch inputs (inverted nav + user switches) before they reach the
//   demo system's general-purpose input port.
//   Per bit: 2-flop synchroniser, then a stability counter, then registered debounced level.
//   Also produces one-cycle rise/fall pulses and a sticky change flag for software polling.
//   Sits between the top-level pad inversion and ibex_demo_system gp_i, in the clk_sys domain.
// PARAMETERS
//   Width           13        number of input bits (matches GpiWidth)
//   DebounceCycles  250000    cycles a new level must be stable before acceptance (5 ms @ 50 MHz); >= 1
//   ResetVal        '0        Width-bit reset value of synchroniser flops and db_o (switch "off")
// PORTS
//   clk_sys_i   in   1      system clock
//   rst_sys_i   in   1      synchronous reset, active high
//   raw_i       in   Width  asynchronous raw switch levels (1 = on)
//   db_o        out  Width  debounced levels
//   rise_o      out  Width  1-cycle pulse per bit when db_o bit goes 0->1
//   fall_o      out  Width  1-cycle pulse per bit when db_o bit goes 1->0
//   changed_o   out  1      sticky: set by any rise/fall, cleared by clr_i
//   clr_i       in   1      1-cycle request to clear changed_o
// BEHAVIOUR
//   - Reset (rst_sys_i high at an edge):
//     - sync1, sync2, db_o <= ResetVal; all counters <= 0.
//     - rise_o, fall_o <= 0; changed_o <= 0.
//     - Reset dominates every other event, including a pending db update.
//   - Synchroniser: sync1 <= raw_i; sync2 <= sync1 (no reset-time sampling of raw_i).
//   - Per-bit counter cnt[i], width $clog2(DebounceCycles+1). Each edge:
//     - sync2[i] == db_o[i]: cnt[i] <= 0 (any bounce back restarts the count).
//     - sync2[i] != db_o[i] and cnt[i] == DebounceCycles-1: db_o[i] <= sync2[i], cnt[i] <= 0.
//     - otherwise: cnt[i] <= cnt[i] + 1. cnt never exceeds DebounceCycles-1; no wrap.
//   - Latency: raw_i held from edge k (first sampled by sync1) -> db_o updates at edge
//     k+1+DebounceCycles (DebounceCycles+2 cycles total). DebounceCycles=1 gives 3 cycles.
//   - Edge pulses: registered at the same edge db_o[i] changes.
//     - rise_o[i] = new value 1; fall_o[i] = new value 0.
//     - Pulses are high for exactly one cycle, then 0.
//     - Multiple bits may pulse in the same cycle.
//   - changed_o: set at the edge where any rise/fall pulse is asserted (i.e. the db_o update edge).
//     - clr_i clears it at the next edge.
//     - clr_i and a new db_o change at the same edge: set wins (changed_o stays 1).
//   - Glitches shorter than DebounceCycles cycles (after sync) never reach db_o and produce no pulses.
//   - Bits are fully independent; no cross-bit state.
// TESTING
//   1 Reset, ResetVal=0, raw_i=0 -> db_o=0, rise/fall/changed=0 for 100 cycles.
//   2 DebounceCycles=8; raw_i[0] 0->1 sampled at edge k
//     -> db_o[0]=1 and rise_o[0]=1 after edge k+9 only; rise_o[0]=0 after edge k+10; changed_o=1.
//   3 DebounceCycles=8; raw_i[3] pulses high for 7 cycles, 10 times (bounce)
//     -> db_o[3] stays 0, no pulses; then held 9 cycles -> fall-free rise on bit 3.
//   4 changed_o=1; clr_i pulse with no activity -> changed_o=0 next cycle;
//     clr_i coincident with a fall_o[5] pulse -> changed_o remains 1.
//   5 raw_i=13'h1FFF simultaneously -> all 13 rise_o bits pulse in the same cycle; db_o=13'h1FFF.
//   6 Assert rst_sys_i when cnt[2]==DebounceCycles-1
//     -> no db_o update, no pulse; after release the count restarts from 0 and takes full latency.

Source files
------------

// File: rtl/gpi_debounce.sv
// gpi_debounce: conditions raw board switch levels for the general-purpose
// input port. Each bit is synchronised with two flops. A new level must then
// stay stable for DebounceCycles cycles before it is accepted. The block also
// produces per-bit rise/fall pulses and a sticky "something changed" flag.
module gpi_debounce #(
  parameter int unsigned      Width          = 13,
  parameter int unsigned      DebounceCycles = 250000,
  parameter logic [Width-1:0] ResetVal       = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] raw_i,
  output logic [Width-1:0] db_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             changed_o,
  input  logic             clr_i
);

  localparam int unsigned     CntW    = $clog2(DebounceCycles + 1);
  // Last count value before a differing level is accepted.
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [Width-1:0] sync1_reg;
  logic [Width-1:0] sync2_reg;
  logic [Width-1:0] db_reg;
  logic [Width-1:0] rise_reg;
  logic [Width-1:0] fall_reg;
  logic [Width-1:0] upd;
  logic             changed_reg;
  logic             changed_next;

  // Two-flop synchroniser; raw_i is not sampled while reset is held.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      sync1_reg <= ResetVal;
      sync2_reg <= ResetVal;
    end else begin
      sync1_reg <= raw_i;
      sync2_reg <= sync1_reg;
    end
  end

  // One independent stability counter per bit.
  for (genvar gi = 0; gi < int'(Width); gi++) begin : g_bit
    logic [CntW-1:0] cnt_reg;
    logic            differ;

    assign differ  = sync2_reg[gi] ^ db_reg[gi];
    assign upd[gi] = differ && (cnt_reg == CntLast);

    // Count while the synchronised level disagrees with db; any agreement
    // (a bounce back) or an accepted update restarts the count.
    always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
        cnt_reg <= '0;
      end else if (!differ || upd[gi]) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CntW'(1);
      end
    end
  end

  // Sticky flag: a new level change wins over a simultaneous clear.
  always_comb begin
    changed_next = changed_reg;
    if (clr_i) begin
      changed_next = 1'b0;
    end
    if (|upd) begin
      changed_next = 1'b1;
    end
  end

  // Debounced level, single-cycle edge pulses and the sticky flag.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      db_reg      <= ResetVal;
      rise_reg    <= '0;
      fall_reg    <= '0;
      changed_reg <= 1'b0;
    end else begin
      db_reg      <= db_reg ^ upd;
      rise_reg    <= upd & ~db_reg;
      fall_reg    <= upd & db_reg;
      changed_reg <= changed_next;
    end
  end

  assign db_o      = db_reg;
  assign rise_o    = rise_reg;
  assign fall_o    = fall_reg;
  assign changed_o = changed_reg;

endmodule

// File: tb/tb_gpi_debounce.sv
// tb_gpi_debounce: directed stimulus for gpi_debounce with DebounceCycles=8.
// A window-based model (a level is accepted when the last D synchronised
// samples all disagree with the current debounced level) predicts every
// output, and it is checked after every clock. Hand-computed literal checks
// pin the expected latency and pulse behaviour.
module tb_gpi_debounce;

  localparam int W = 13;
  localparam int D = 8;

  logic          main_clk_buf = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic [W-1:0]  raw = '0;
  logic [W-1:0]  db;
  logic [W-1:0]  rise;
  logic [W-1:0]  fall;
  logic          changed;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  logic [W-1:0]  m_s1 = '0;
  logic [W-1:0]  m_s2 = '0;
  logic [W-1:0]  m_db = '0;
  logic [W-1:0]  m_rise = '0;
  logic [W-1:0]  m_fall = '0;
  logic          m_chg = 1'b0;
  logic [W-1:0]  hist[$];

  gpi_debounce #(
    .Width(W),
    .DebounceCycles(D),
    .ResetVal('0)
  ) dut (
    .clk_sys_i(main_clk_buf),
    .rst_sys_i(rst),
    .raw_i(raw),
    .db_o(db),
    .rise_o(rise),
    .fall_o(fall),
    .changed_o(changed),
    .clr_i(clr)
  );

  always #5 main_clk_buf = ~main_clk_buf;

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one edge from the current inputs, let the DUT take
  // the same edge, then compare all outputs on the falling edge.
  task automatic step();
    logic [W-1:0] seen;
    logic [W-1:0] all_diff;
    logic [W-1:0] flip;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_db = '0;
      m_rise = '0; m_fall = '0; m_chg = 1'b0;
      hist.delete();
    end else begin
      seen = m_s2;
      hist.push_back(seen);
      if (hist.size() > D) void'(hist.pop_front());
      flip = '0;
      if (hist.size() == D) begin
        all_diff = '1;
        foreach (hist[j]) all_diff &= hist[j] ^ m_db;
        flip = all_diff;
      end
      m_rise = flip & ~m_db;
      m_fall = flip & m_db;
      m_db   = m_db ^ flip;
      if (|flip)    m_chg = 1'b1;
      else if (clr) m_chg = 1'b0;
      m_s2 = m_s1;
      m_s1 = raw;
    end
    @(posedge main_clk_buf);
    @(negedge main_clk_buf);
    chk("db", 32'(db), 32'(m_db));
    chk("rise", 32'(rise), 32'(m_rise));
    chk("fall", 32'(fall), 32'(m_fall));
    chk("changed", 32'(changed), 32'(m_chg));
    $display("t=%0t rst=%0b raw=%04h clr=%0b -> db=%04h rise=%04h fall=%04h chg=%0b",
             $time, rst, raw, clr, db, rise, fall, changed);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    @(negedge main_clk_buf);
    // 1: reset then 100 idle cycles
    rst = 1'b1; raw = '0; clr = 1'b0;
    steps(2);
    rst = 1'b0;
    steps(100);
    chk("t1_db", 32'(db), 32'h0);
    chk("t1_pulses", 32'(rise | fall), 32'h0);
    chk("t1_changed", 32'(changed), 32'h0);

    // 2: bit 0 rises; accepted at edge k+9
    raw[0] = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      step();
      if (i == 8)  chk("t2_db0_early", 32'(db[0]), 32'h0);
      if (i == 9)  chk("t2_rise0", 32'({db[0], rise[0]}), 32'h3);
      if (i == 10) chk("t2_rise0_end", 32'({rise[0], changed}), 32'h1);
    end

    // 3: bounce on bit 3 (7 high, 2 low, ten times) then a stable hold
    clr = 1'b1; step(); clr = 1'b0;
    for (int r = 0; r < 10; r++) begin
      raw[3] = 1'b1; steps(7);
      raw[3] = 1'b0; steps(2);
    end
    chk("t3_db3_bounce", 32'(db[3]), 32'h0);
    chk("t3_changed_bounce", 32'(changed), 32'h0);
    raw[3] = 1'b1;
    steps(9);
    chk("t3_db3_pre", 32'(db[3]), 32'h0);
    step();
    chk("t3_rise3", 32'({db[3], rise[3], fall[3]}), 32'h6);

    // 4: plain clear, then clear coincident with a fall on bit 5
    clr = 1'b1; step(); clr = 1'b0;
    chk("t4_cleared", 32'(changed), 32'h0);
    raw[5] = 1'b1; steps(12);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t4_cleared2", 32'(changed), 32'h0);
    raw[5] = 1'b0;
    steps(9);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t4_fall5", 32'({fall[5], db[5]}), 32'h2);
    chk("t4_set_wins", 32'(changed), 32'h1);

    // 5: all bits rise together from a clean reset
    rst = 1'b1; raw = '0; step(); rst = 1'b0;
    chk("t5_reset_db", 32'(db), 32'h0);
    steps(3);
    raw = 13'h1FFF;
    steps(9);
    chk("t5_db_pre", 32'(db), 32'h0);
    step();
    chk("t5_rise_all", 32'(rise), 32'h1FFF);
    chk("t5_db_all", 32'(db), 32'h1FFF);

    // 6: reset lands exactly when bit 2's count would accept
    rst = 1'b1; raw = '0; step(); rst = 1'b0;
    steps(3);
    raw[2] = 1'b1;
    steps(9);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_no_update", 32'({db[2], rise[2]}), 32'h0);
    for (int j = 1; j <= 10; j++) begin
      step();
      if (j == 9)  chk("t6_db2_pre", 32'(db[2]), 32'h0);
      if (j == 10) chk("t6_rise2", 32'({db[2], rise[2]}), 32'h3);
    end
    steps(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
